ps2_kb_decoder: RTL and testbench

// - Producer end of the 8-bit held-key bitmap consumed by user_control's kb_in port.
// - Receives PS/2 keyboard frames and decodes scan-code set 2, including E0 (extended) and F0 (break) prefixes.
// - Maintains one "held" bit per mapped key. Sits between the board PS/2 pins and user_control.

---
 rtl/ps2_kb_decoder_pkg.sv | 57 +++++
 rtl/ps2_kb_decoder_if.sv | 27 ++
 rtl/ps2_kb_decoder_rx.sv | 162 ++++++++++++++++
 rtl/ps2_kb_decoder.sv | 90 +++++++++
 tb/tb_ps2_kb_decoder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_kb_decoder_pkg.sv
// Shared key-bit indices, scan-code constants and the set-2 key lookup for the PS/2 keyboard decoder.
// Bit indices match the held-key bitmap consumed by user_control's kb_in.
package ps2_kb_decoder_pkg;

  localparam int KB_FORWARD     = 7;
  localparam int KB_BACKWARD    = 6;
  localparam int KB_TURN_LEFT   = 5;
  localparam int KB_TURN_RIGHT  = 4;
  localparam int KB_TRANS_UP    = 3;
  localparam int KB_TRANS_DOWN  = 2;
  localparam int KB_TRANS_LEFT  = 1;
  localparam int KB_TRANS_RIGHT = 0;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Keypad arrows share codes with the E0 cursor keys; only the E0 variants are mapped.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = 3'd0;
    case ({ext, code})
      {1'b0, SC_W}:     r.idx = 3'(KB_FORWARD);
      {1'b0, SC_S}:     r.idx = 3'(KB_BACKWARD);
      {1'b0, SC_A}:     r.idx = 3'(KB_TURN_LEFT);
      {1'b0, SC_D}:     r.idx = 3'(KB_TURN_RIGHT);
      {1'b1, SC_UP}:    r.idx = 3'(KB_TRANS_UP);
      {1'b1, SC_DOWN}:  r.idx = 3'(KB_TRANS_DOWN);
      {1'b1, SC_LEFT}:  r.idx = 3'(KB_TRANS_LEFT);
      {1'b1, SC_RIGHT}: r.idx = 3'(KB_TRANS_RIGHT);
      default:          r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_kb_decoder_if.sv
// Output bundle of the PS/2 keyboard decoder: held-key bitmap, last scan code and status pulses.
// err_count_out exists only when KB_ERR_CNT_EN is defined.
interface ps2_kb_decoder_if;

  logic [7:0] kb_out;
  logic [7:0] scancode_out;
  logic       scancode_valid_out;
  logic       frame_err_out;
`ifdef KB_ERR_CNT_EN
  logic [7:0] err_count_out;

  modport master (
    output kb_out, scancode_out, scancode_valid_out, frame_err_out, err_count_out
  );
  modport slave (
    input kb_out, scancode_out, scancode_valid_out, frame_err_out, err_count_out
  );
`else
  modport master (
    output kb_out, scancode_out, scancode_valid_out, frame_err_out
  );
  modport slave (
    input kb_out, scancode_out, scancode_valid_out, frame_err_out
  );
`endif

endinterface

// File: rtl/ps2_kb_decoder_rx.sv
// PS/2 receiver: pin synchronisers, clock stability filter, 11-bit frame FSM and inter-edge watchdog.
// state     | meaning
// RX_IDLE   | waiting for a start bit (data=0 at a falling edge)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | checking odd parity over data+parity
// RX_STOP   | expecting stop bit = 1, then publishing the byte
module ps2_kb_decoder_rx
  import ps2_kb_decoder_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIMEOUT_US  = 200,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int              FLT_W   = $clog2(FILTER_LEN + 1);
  localparam logic [FLT_W-1:0] FLT_LOAD = FLT_W'(FILTER_LEN - 1);
  localparam longint          WD_CYC  = (longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ)
                                         + longint'(999_999)) / longint'(1_000_000);
  localparam int              WD_W    = $clog2(WD_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(WD_CYC);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic                   clk_filt;
  logic [FLT_W-1:0]       flt_cnt;
  logic                   fall_edge;
  logic [WD_W-1:0]        wd_cnt;
  logic                   wd_expired;

  rx_state_t  state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic       par_q, par_nxt;
  logic [7:0] data_q, data_nxt;
  logic       valid_q, valid_nxt;
  logic       err_q, err_nxt;

  // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a false start edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data_in};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      flt_cnt  <= FLT_LOAD;
    end else if (clk_s == clk_filt) begin
      flt_cnt <= FLT_LOAD;
    end else if (flt_cnt == '0) begin
      clk_filt <= clk_s;
      flt_cnt  <= FLT_LOAD;
    end else begin
      flt_cnt <= flt_cnt - FLT_W'(1);
    end
  end

  assign fall_edge = clk_filt & ~clk_s & (flt_cnt == '0);

  // Held at full load while idle; saturates at zero instead of wrapping.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= WD_LOAD;
    end else if (fall_edge || state == RX_IDLE) begin
      wd_cnt <= WD_LOAD;
    end else if (wd_cnt != '0) begin
      wd_cnt <= wd_cnt - WD_W'(1);
    end
  end

  assign wd_expired = (state != RX_IDLE) && (wd_cnt == '0);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift_q <= shift_nxt;
      par_q   <= par_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    par_nxt     = par_q;
    data_nxt    = data_q;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    if (wd_expired) begin
      state_nxt = RX_IDLE;
      err_nxt   = 1'b1;
    end else if (fall_edge) begin
      case (state)
        RX_IDLE: begin
          if (!dat_s) begin
            state_nxt   = RX_DATA;
            bit_cnt_nxt = '0;
            par_nxt     = 1'b0;
          end
        end
        RX_DATA: begin
          shift_nxt   = {dat_s, shift_q[7:1]};
          par_nxt     = par_q ^ dat_s;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        end
        RX_PARITY: begin
          if (par_q ^ dat_s) begin
            state_nxt = RX_STOP;
          end else begin
            state_nxt = RX_IDLE;
            err_nxt   = 1'b1;
          end
        end
        RX_STOP: begin
          state_nxt = RX_IDLE;
          if (dat_s) begin
            data_nxt  = shift_q;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  assign rx_byte  = data_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/ps2_kb_decoder.sv
// PS/2 set-2 keyboard decoder: E0/F0 prefix tracking, key map lookup and held-key bitmap.
// Define KB_ERR_CNT_EN to add a saturating frame-error counter on err_count_out.
module ps2_kb_decoder
  import ps2_kb_decoder_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIMEOUT_US  = 200,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ps2_clk_in,
  input  logic             ps2_data_in,
  ps2_kb_decoder_if.master kb_if
);

  logic [1:0] rst_sync;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  logic       ext_q, brk_q;
  logic [7:0] kb_q;
  key_hit_t   hit;

  // Reset asserts asynchronously (clearing outputs at once) and releases on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  ps2_kb_decoder_rx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TIMEOUT_US  (TIMEOUT_US),
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_rx (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err)
  );

  assign hit = key_lookup(ext_q, rx_byte);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      kb_q  <= '0;
    end else if (rx_err) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_E0) begin
        ext_q <= 1'b1;
      end else if (rx_byte == SC_F0) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        // BAT OK means the keyboard was re-plugged, so nothing can still be held.
        if (rx_byte == SC_BAT_OK) kb_q <= '0;
        else if (hit.hit)         kb_q[hit.idx] <= ~brk_q;
      end
    end
  end

  assign kb_if.kb_out             = kb_q;
  assign kb_if.scancode_out       = rx_byte;
  assign kb_if.scancode_valid_out = rx_valid;
  assign kb_if.frame_err_out      = rx_err;

`ifdef KB_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                         err_cnt <= '0;
    else if (rx_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  assign kb_if.err_count_out = err_cnt;
`endif

endmodule

// File: tb/tb_ps2_kb_decoder.sv
// Bench for ps2_kb_decoder: directed scenarios plus random frames against a key-map model.
`timescale 1ns/1ps
module tb_ps2_kb_decoder;

  logic clk_in      = 1'b0;
  logic rst_n_in    = 1'b0;
  logic ps2_clk_in  = 1'b1;
  logic ps2_data_in = 1'b1;

  always #500 clk_in = ~clk_in;

  ps2_kb_decoder_if bus();

  ps2_kb_decoder #(
    .CLK_FREQ_HZ (1_000_000),
    .TIMEOUT_US  (200),
    .SYNC_STAGES (2),
    .FILTER_LEN  (8)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .kb_if       (bus)
  );

  int n_chk = 0, n_fail = 0;
  int n_valid = 0, n_err = 0;
  int key_map[int];
  bit m_ext, m_brk;
  logic [7:0] m_kb;
  int m_errs;

  always @(negedge clk_in) begin
    if (bus.scancode_valid_out === 1'b1) n_valid <= n_valid + 1;
    if (bus.frame_err_out === 1'b1)      n_err   <= n_err + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  task automatic send_bit(input bit v, input int hp);
    ps2_data_in = v;
    wait_cyc(hp);
    ps2_clk_in = 1'b0;
    wait_cyc(hp);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int ndata, input int hp);
    send_bit(1'b0, hp);
    for (int i = 0; i < ndata; i++) send_bit(b[i], hp);
    if (ndata == 8) begin
      send_bit((~^b) ^ bad_par, hp);
      send_bit(1'b1, hp);
    end
    ps2_data_in = 1'b1;
  endtask

  function automatic void model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = (m_ext ? 256 : 0) + int'(b);
      if (b == 8'hAA) m_kb = 8'h00;
      else if (key_map.exists(k)) m_kb[key_map[k]] = ~m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_err();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_errs++;
  endfunction

  task automatic check_status(input string tag);
    check_val({tag, "_kb"}, bus.kb_out, m_kb);
`ifdef KB_ERR_CNT_EN
    check_val({tag, "_ecnt"}, bus.err_count_out, (m_errs > 255) ? 255 : m_errs);
`endif
  endtask

  task automatic xfer(input logic [7:0] b, input bit bad, input int hp, input string tag);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_frame(b, bad, 8, hp);
    wait_cyc(4);
    #1;
    if (bad) model_err();
    else     model_byte(b);
    check_val({tag, "_valid"}, n_valid - v0, bad ? 0 : 1);
    check_val({tag, "_err"}, n_err - e0, bad ? 1 : 0);
    if (!bad) check_val({tag, "_sc"}, bus.scancode_out, b);
    check_status(tag);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] pool [12];
    logic [7:0] b;
    int sel;

    key_map[32'h01D] = 7; key_map[32'h01B] = 6; key_map[32'h01C] = 5; key_map[32'h023] = 4;
    key_map[32'h175] = 3; key_map[32'h172] = 2; key_map[32'h16B] = 1; key_map[32'h174] = 0;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hAA, 8'h00};
    m_ext = 0; m_brk = 0; m_kb = 8'h00; m_errs = 0;

    wait_cyc(3);
    #1;
    check_val("rst_kb", bus.kb_out, 8'h00);
    check_val("rst_sc", bus.scancode_out, 8'h00);
    check_val("rst_valid", bus.scancode_valid_out, 1'b0);
    check_val("rst_err", bus.frame_err_out, 1'b0);
    check_status("rst");
    rst_n_in = 1'b1;
    wait_cyc(5);

    xfer(8'h1D, 0, 40, "w_make");
    check_val("w_make_kb80", bus.kb_out, 8'h80);
    xfer(8'hF0, 0, 40, "w_f0");
    xfer(8'h1D, 0, 40, "w_brk");
    check_val("w_brk_kb00", bus.kb_out, 8'h00);

    xfer(8'hE0, 0, 40, "up_e0");
    xfer(8'h75, 0, 40, "up_make");
    xfer(8'h1C, 0, 40, "a_make");
    check_val("up_a_kb28", bus.kb_out, 8'h28);
    xfer(8'hE0, 0, 40, "upb_e0");
    xfer(8'hF0, 0, 40, "upb_f0");
    xfer(8'h75, 0, 40, "up_brk");
    check_val("up_brk_kb20", bus.kb_out, 8'h20);

    xfer(8'h1B, 1, 40, "s_badpar");
    check_val("badpar_kb20", bus.kb_out, 8'h20);

    // Truncated frame: the watchdog must abort it and the next frame must decode cleanly.
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1B, 0, 4, 40);
    wait_cyc(300);
    #1;
    model_err();
    check_val("tmo_valid", n_valid - v0, 0);
    check_val("tmo_err", n_err - e0, 1);
    check_status("tmo");
    xfer(8'h23, 0, 40, "d_make");
    check_val("d_make_bit4", bus.kb_out[4], 1'b1);

    xfer(8'h1D, 0, 40, "hold_w");
    for (int i = 0; i < 5; i++) xfer(8'h1D, 0, 30, "typematic");
    xfer(8'hAA, 0, 40, "bat_ok");
    check_val("bat_kb00", bus.kb_out, 8'h00);

    v0 = n_valid; e0 = n_err;
    ps2_data_in = 1'b0;
    ps2_clk_in = 1'b0;
    wait_cyc(3);
    ps2_clk_in = 1'b1;
    ps2_data_in = 1'b1;
    wait_cyc(20);
    #1;
    check_val("glitch_valid", n_valid - v0, 0);
    check_val("glitch_err", n_err - e0, 0);
    xfer(8'h1C, 0, 40, "post_glitch");

    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 11);
      b = (sel == 11) ? 8'($urandom) : pool[sel];
      xfer(b, ($urandom_range(0, 7) == 0), $urandom_range(25, 45), "rand");
    end

    xfer(8'h1D, 0, 40, "pre_rst_a");
    xfer(8'h1D, 0, 40, "pre_rst_b");
    send_frame(8'h55, 0, 3, 40);
    rst_n_in = 1'b0;
    #1;
    m_kb = 8'h00; m_ext = 0; m_brk = 0; m_errs = 0;
    check_val("midrst_kb", bus.kb_out, 8'h00);
    check_val("midrst_sc", bus.scancode_out, 8'h00);
    check_val("midrst_valid", bus.scancode_valid_out, 1'b0);
    check_val("midrst_err", bus.frame_err_out, 1'b0);
    check_status("midrst");
    wait_cyc(5);
    rst_n_in = 1'b1;
    v0 = n_valid; e0 = n_err;
    wait_cyc(300);
    #1;
    check_val("postrst_valid", n_valid - v0, 0);
    check_val("postrst_err", n_err - e0, 0);
    xfer(8'h23, 0, 40, "postrst_d");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
